// File: rtl/ahb_pio_arb2.sv
// Two-master AHB-Lite arbiter sharing one slave. Each master gets a one-entry
// address-phase hold buffer; contention is resolved round-robin.
module ahb_pio_arb2 #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          HCLK,
    input  logic          HRESETn,

    input  logic [AW-1:0] m0_haddr,
    input  logic [1:0]    m0_htrans,
    input  logic [2:0]    m0_hsize,
    input  logic [3:0]    m0_hprot,
    input  logic          m0_hwrite,
    input  logic [DW-1:0] m0_hwdata,
    output logic          m0_hready,
    output logic [DW-1:0] m0_hrdata,
    output logic          m0_hresp,

    input  logic [AW-1:0] m1_haddr,
    input  logic [1:0]    m1_htrans,
    input  logic [2:0]    m1_hsize,
    input  logic [3:0]    m1_hprot,
    input  logic          m1_hwrite,
    input  logic [DW-1:0] m1_hwdata,
    output logic          m1_hready,
    output logic [DW-1:0] m1_hrdata,
    output logic          m1_hresp,

    output logic          s_hsel,
    output logic [AW-1:0] s_haddr,
    output logic [1:0]    s_htrans,
    output logic [2:0]    s_hsize,
    output logic [3:0]    s_hprot,
    output logic          s_hwrite,
    output logic [DW-1:0] s_hwdata,
    output logic          s_hready,
    input  logic          s_hreadyout,
    input  logic [DW-1:0] s_hrdata,
    input  logic          s_hresp
);

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    logic          hold_v0, hold_v1;
    logic [AW-1:0] hold_addr0, hold_addr1;
    logic [2:0]    hold_size0, hold_size1;
    logic [3:0]    hold_prot0, hold_prot1;
    logic          hold_write0, hold_write1;
    logic          dp_v, dp_own, prio;

    logic          acc0, acc1, req0, req1;
    logic          issue, win, grant0, grant1;

    // Handshake: mN_hready=1 means the master's current address is accepted
    // and its outstanding data phase is complete; a held request or a stalled
    // own data phase pulls it low so the master keeps address/wdata stable.
    always_comb begin
        m0_hready = 1'b1;
        m1_hready = 1'b1;
        if (hold_v0)                m0_hready = 1'b0;
        else if (dp_v && !dp_own)   m0_hready = s_hreadyout;
        if (hold_v1)                m1_hready = 1'b0;
        else if (dp_v && dp_own)    m1_hready = s_hreadyout;
    end

    always_comb begin
        acc0   = m0_hready && (m0_htrans == HTRANS_NONSEQ || m0_htrans == HTRANS_SEQ);
        acc1   = m1_hready && (m1_htrans == HTRANS_NONSEQ || m1_htrans == HTRANS_SEQ);
        req0   = hold_v0 | acc0;
        req1   = hold_v1 | acc1;
        issue  = HRESETn & s_hreadyout & (req0 | req1);
        win    = (req0 & req1) ? prio : req1;
        grant0 = issue & ~win;
        grant1 = issue & win;
    end

    // Bursts are reissued as NONSEQ because interleaving breaks SEQ continuity.
    always_comb begin
        s_hsel   = 1'b0;
        s_htrans = HTRANS_IDLE;
        s_haddr  = '0;
        s_hsize  = '0;
        s_hprot  = '0;
        s_hwrite = 1'b0;
        if (issue) begin
            s_hsel   = 1'b1;
            s_htrans = HTRANS_NONSEQ;
            if (win) begin
                s_haddr  = hold_v1 ? hold_addr1  : m1_haddr;
                s_hsize  = hold_v1 ? hold_size1  : m1_hsize;
                s_hprot  = hold_v1 ? hold_prot1  : m1_hprot;
                s_hwrite = hold_v1 ? hold_write1 : m1_hwrite;
            end else begin
                s_haddr  = hold_v0 ? hold_addr0  : m0_haddr;
                s_hsize  = hold_v0 ? hold_size0  : m0_hsize;
                s_hprot  = hold_v0 ? hold_prot0  : m0_hprot;
                s_hwrite = hold_v0 ? hold_write0 : m0_hwrite;
            end
        end
    end

    always_comb begin
        s_hready  = s_hreadyout;
        s_hwdata  = dp_own ? m1_hwdata : m0_hwdata;
        m0_hrdata = s_hrdata;
        m1_hrdata = s_hrdata;
        m0_hresp  = (dp_v && !dp_own) ? s_hresp : 1'b0;
        m1_hresp  = (dp_v &&  dp_own) ? s_hresp : 1'b0;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            hold_v0     <= 1'b0;
            hold_v1     <= 1'b0;
            hold_addr0  <= '0;
            hold_addr1  <= '0;
            hold_size0  <= '0;
            hold_size1  <= '0;
            hold_prot0  <= '0;
            hold_prot1  <= '0;
            hold_write0 <= 1'b0;
            hold_write1 <= 1'b0;
            dp_v        <= 1'b0;
            dp_own      <= 1'b0;
            prio        <= 1'b0;
        end else begin
            if (acc0 && !grant0) begin
                hold_v0     <= 1'b1;
                hold_addr0  <= m0_haddr;
                hold_size0  <= m0_hsize;
                hold_prot0  <= m0_hprot;
                hold_write0 <= m0_hwrite;
            end else if (grant0) begin
                hold_v0 <= 1'b0;
            end

            if (acc1 && !grant1) begin
                hold_v1     <= 1'b1;
                hold_addr1  <= m1_haddr;
                hold_size1  <= m1_hsize;
                hold_prot1  <= m1_hprot;
                hold_write1 <= m1_hwrite;
            end else if (grant1) begin
                hold_v1 <= 1'b0;
            end

            // Only a contended grant moves priority, and it moves to the loser.
            if (issue && req0 && req1)
                prio <= ~win;

            if (s_hreadyout) begin
                dp_v   <= issue;
                dp_own <= win;
            end
        end
    end

endmodule

// File: tb/tb_ahb_pio_arb2.sv
// Directed bench for ahb_pio_arb2: slave address phases are scoreboarded,
// master-side ready/response/data are checked at fixed cycles.
module tb_ahb_pio_arb2;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int RW = 40;
    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] NONSEQ = 2'b10;
    localparam logic [1:0] SEQ    = 2'b11;
    localparam logic [3:0] PROT0  = 4'b0011;
    localparam logic [3:0] PROT1  = 4'b0001;

    logic          HCLK, HRESETn;
    logic [AW-1:0] m0_haddr, m1_haddr;
    logic [1:0]    m0_htrans, m1_htrans;
    logic [2:0]    m0_hsize, m1_hsize;
    logic [3:0]    m0_hprot, m1_hprot;
    logic          m0_hwrite, m1_hwrite;
    logic [DW-1:0] m0_hwdata, m1_hwdata;
    logic          m0_hready, m1_hready;
    logic [DW-1:0] m0_hrdata, m1_hrdata;
    logic          m0_hresp, m1_hresp;
    logic          s_hsel, s_hwrite, s_hready, s_hreadyout, s_hresp;
    logic [AW-1:0] s_haddr;
    logic [1:0]    s_htrans;
    logic [2:0]    s_hsize;
    logic [3:0]    s_hprot;
    logic [DW-1:0] s_hwdata, s_hrdata;

    int checks = 0;
    int errors = 0;
    logic [RW-1:0] exp_q[$];
    logic [RW-1:0] mon_e;

    ahb_pio_arb2 #(.AW(AW), .DW(DW)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .m0_haddr(m0_haddr), .m0_htrans(m0_htrans), .m0_hsize(m0_hsize),
        .m0_hprot(m0_hprot), .m0_hwrite(m0_hwrite), .m0_hwdata(m0_hwdata),
        .m0_hready(m0_hready), .m0_hrdata(m0_hrdata), .m0_hresp(m0_hresp),
        .m1_haddr(m1_haddr), .m1_htrans(m1_htrans), .m1_hsize(m1_hsize),
        .m1_hprot(m1_hprot), .m1_hwrite(m1_hwrite), .m1_hwdata(m1_hwdata),
        .m1_hready(m1_hready), .m1_hrdata(m1_hrdata), .m1_hresp(m1_hresp),
        .s_hsel(s_hsel), .s_haddr(s_haddr), .s_htrans(s_htrans),
        .s_hsize(s_hsize), .s_hprot(s_hprot), .s_hwrite(s_hwrite),
        .s_hwdata(s_hwdata), .s_hready(s_hready), .s_hreadyout(s_hreadyout),
        .s_hrdata(s_hrdata), .s_hresp(s_hresp)
    );

    // clock / reset
    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic m0_drv(input logic [1:0] tr, input logic [31:0] a, input logic w);
        m0_htrans = tr; m0_haddr = a; m0_hwrite = w; m0_hsize = 3'b010; m0_hprot = PROT0;
    endtask

    task automatic m1_drv(input logic [1:0] tr, input logic [31:0] a, input logic w);
        m1_htrans = tr; m1_haddr = a; m1_hwrite = w; m1_hsize = 3'b010; m1_hprot = PROT1;
    endtask

    task automatic push(input logic [31:0] a, input logic w, input logic [3:0] p);
        exp_q.push_back({a, w, 3'b010, p});
    endtask

    task automatic sample();
        @(negedge HCLK);
    endtask

    task automatic advance();
        @(posedge HCLK);
        #1;
    endtask

    // scoreboard monitor: every slave address phase must match the next expected one
    always @(negedge HCLK) begin
        if (s_hsel === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_issue actual_addr=%0h expected=none", s_haddr);
            end else begin
                mon_e = exp_q.pop_front();
                chk("slave_addr_phase", {24'd0, s_haddr, s_hwrite, s_hsize, s_hprot}, {24'd0, mon_e});
                chk("slave_htrans", {62'd0, s_htrans}, {62'd0, NONSEQ});
            end
        end
    end

    initial begin
        HRESETn = 1'b0;
        m0_drv(IDLE, 32'h0, 1'b0);
        m1_drv(IDLE, 32'h0, 1'b0);
        m0_hwdata = '0; m1_hwdata = '0;
        s_hreadyout = 1'b1; s_hresp = 1'b0; s_hrdata = '0;
        repeat (2) @(posedge HCLK);
        #1;

        sample();
        chk("rst_m0_hready", m0_hready, 1);
        chk("rst_m1_hready", m1_hready, 1);
        chk("rst_s_hsel",    s_hsel, 0);
        chk("rst_s_htrans",  s_htrans, 0);
        chk("rst_m0_hresp",  m0_hresp, 0);
        advance();
        HRESETn = 1'b1;
        sample(); advance();

        // uncontended M0 write
        m0_drv(NONSEQ, 32'h4000_0000, 1'b1); push(32'h4000_0000, 1'b1, PROT0);
        sample();
        chk("t1_m0_hready_addr", m0_hready, 1);
        chk("t1_s_htrans", s_htrans, NONSEQ);
        advance();
        m0_drv(IDLE, 32'h0, 1'b0); m0_hwdata = 32'hA5A5_0000;
        sample();
        chk("t1_s_hwdata", s_hwdata, 32'hA5A5_0000);
        chk("t1_m0_hready_data", m0_hready, 1);
        advance();

        // contention with prio=M0, then with prio=M1
        m0_drv(NONSEQ, 32'h4000_0010, 1'b1); m1_drv(NONSEQ, 32'h4000_0020, 1'b0);
        push(32'h4000_0010, 1'b1, PROT0); push(32'h4000_0020, 1'b0, PROT1);
        sample();
        chk("t2_m1_hready_T", m1_hready, 1);
        advance();
        m0_drv(IDLE, 32'h0, 1'b0); m1_drv(IDLE, 32'h0, 1'b0); m0_hwdata = 32'h1111_1111;
        sample();
        chk("t2_m1_hready_T1", m1_hready, 0);
        chk("t2_s_hwdata_m0", s_hwdata, 32'h1111_1111);
        advance();
        s_hrdata = 32'hCAFE_0001;
        sample();
        chk("t2_m1_hready_T2", m1_hready, 1);
        chk("t2_m1_hrdata", m1_hrdata, 32'hCAFE_0001);
        advance();
        m0_drv(NONSEQ, 32'h4000_0030, 1'b0); m1_drv(NONSEQ, 32'h4000_0040, 1'b0);
        push(32'h4000_0040, 1'b0, PROT1); push(32'h4000_0030, 1'b0, PROT0);
        sample();
        chk("t2b_m0_hready_T", m0_hready, 1);
        advance();
        m0_drv(IDLE, 32'h0, 1'b0); m1_drv(IDLE, 32'h0, 1'b0);
        sample();
        chk("t2b_m0_hready_T1", m0_hready, 0);
        chk("t2b_m1_hready_T1", m1_hready, 1);
        advance();
        sample();
        chk("t2b_m0_hready_T2", m0_hready, 1);
        advance();

        // two slave wait states on an M0 read while M1 requests
        m0_drv(NONSEQ, 32'h4000_0050, 1'b0); push(32'h4000_0050, 1'b0, PROT0);
        sample(); advance();
        m0_drv(IDLE, 32'h0, 1'b0); m1_drv(NONSEQ, 32'h4000_0060, 1'b1);
        push(32'h4000_0060, 1'b1, PROT1); s_hreadyout = 1'b0;
        sample();
        chk("t3_s_hsel_ws1", s_hsel, 0);
        chk("t3_m0_hready_ws1", m0_hready, 0);
        chk("t3_m1_hready_ws1", m1_hready, 1);
        advance();
        m1_drv(IDLE, 32'h0, 1'b0); m1_hwdata = 32'h6060_6060;
        sample();
        chk("t3_m1_hready_ws2", m1_hready, 0);
        chk("t3_s_hsel_ws2", s_hsel, 0);
        advance();
        s_hreadyout = 1'b1; s_hrdata = 32'h5A5A_0050;
        sample();
        chk("t3_m0_hready_done", m0_hready, 1);
        chk("t3_m0_hrdata", m0_hrdata, 32'h5A5A_0050);
        chk("t3_s_hsel_issue", s_hsel, 1);
        advance();
        sample();
        chk("t3_s_hwdata_m1", s_hwdata, 32'h6060_6060);
        chk("t3_m1_hready_data", m1_hready, 1);
        advance();

        // two-cycle ERROR on an M1 transfer
        m1_drv(NONSEQ, 32'h4000_0070, 1'b0); push(32'h4000_0070, 1'b0, PROT1);
        sample(); advance();
        m1_drv(IDLE, 32'h0, 1'b0); s_hreadyout = 1'b0; s_hresp = 1'b1;
        sample();
        chk("t4_m1_hresp_c1", m1_hresp, 1);
        chk("t4_m1_hready_c1", m1_hready, 0);
        chk("t4_m0_hresp_c1", m0_hresp, 0);
        advance();
        s_hreadyout = 1'b1;
        sample();
        chk("t4_m1_hresp_c2", m1_hresp, 1);
        chk("t4_m1_hready_c2", m1_hready, 1);
        chk("t4_m0_hresp_c2", m0_hresp, 0);
        advance();
        s_hresp = 1'b0;

        // 4-beat INCR burst reissued as back-to-back NONSEQ
        for (int i = 0; i < 4; i++) begin
            m0_drv((i == 0) ? NONSEQ : SEQ, 32'h4000_0100 + 32'(4 * i), 1'b1);
            push(32'h4000_0100 + 32'(4 * i), 1'b1, PROT0);
            sample();
            chk("t5_burst_m0_hready", m0_hready, 1);
            chk("t5_burst_htrans", s_htrans, NONSEQ);
            advance();
        end
        m0_drv(IDLE, 32'h0, 1'b0);
        sample(); advance();

        // reset while an M1 hold is pending
        m0_drv(NONSEQ, 32'h4000_0200, 1'b1); m1_drv(NONSEQ, 32'h4000_0300, 1'b0);
        push(32'h4000_0200, 1'b1, PROT0);
        sample(); advance();
        m0_drv(IDLE, 32'h0, 1'b0); m1_drv(IDLE, 32'h0, 1'b0);
        HRESETn = 1'b0;
        sample();
        chk("t6_s_hsel", s_hsel, 0);
        chk("t6_s_htrans", s_htrans, IDLE);
        chk("t6_m0_hready", m0_hready, 1);
        chk("t6_m1_hready", m1_hready, 1);
        advance(); advance();
        HRESETn = 1'b1;
        repeat (3) begin
            sample(); advance();
        end
        chk("exp_q_empty", 64'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
